vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, the successor to the fixed 640x480 generator. Produces HSYNC/VSYNC, blanking, display enable, pixel coordinates and pixel clock from the 50 MHz system clock. Adds generic timing, programmable sync polarity, start/stop control with frame-aligned shutdown, and frame/line strobes for downstream framebuffer readers. Sits between the clock source and the pixel-colour logic / video DAC.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC_W, 96, HSYNC pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC_W, 2, VSYNC pulse width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, HSYNC level during pulse
VSYNC_POL, 0, VSYNC level during pulse
CLK_DIV, 2, clk50 cycles per pixel; even and >=2; elaboration error otherwise

Ports:
clk50  in  1  system clock
N_RESET  in  1  asynchronous active-low reset
ENABLE  in  1  run request
VGA_CLOCK  out  1  pixel clock to DAC
PIX_TICK  out  1  one-clk50 strobe per pixel period
H_SYNC  out  1  horizontal sync
V_SYNC  out  1  vertical sync
N_SYNC  out  1  constant 0
N_BLANK  out  1  low during blanking
DISP_EN  out  1  high for visible pixel
XPOS  out  XW  pixel column; XW = $clog2(H_TOTAL)
YPOS  out  YW  pixel row; YW = $clog2(V_TOTAL)
LINE_START  out  1  pulse at column 0 of every line
FRAME_START  out  1  pulse at pixel (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC_W+H_BP; V_TOTAL likewise.
- Reset (N_RESET low, async): div counter, hc, vc = 0; state IDLE; H_SYNC=~HSYNC_POL, V_SYNC=~VSYNC_POL; DISP_EN, N_BLANK, PIX_TICK, LINE_START, FRAME_START, VGA_CLOCK = 0; XPOS=YPOS=0.
- Divider: free-running, 0..CLK_DIV-1, all states. PIX_TICK registered, high for the cycle after divcnt==CLK_DIV-1. VGA_CLOCK registered, high while divcnt in [CLK_DIV/2, CLK_DIV-1]; rising edge mid-pixel, outputs stable.
- Outputs registered from (hc,vc) on tick cycles; change on the clk50 edge after the tick and hold for CLK_DIV cycles. Counters advance on the same tick: hc wraps at H_TOTAL-1 and increments vc; vc wraps at V_TOTAL-1.
- Decode (RUN/DRAIN): DISP_EN = hc<H_ACTIVE && vc<V_ACTIVE; N_BLANK = DISP_EN. H_SYNC active exactly for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC_W). V_SYNC active exactly for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC_W), all columns of those lines. XPOS/YPOS = hc/vc when DISP_EN, else 0.
- LINE_START: single clk50 pulse with outputs for hc=0. FRAME_START: single clk50 pulse with outputs for hc=0,vc=0.
- FSM:
  IDLE: counters held 0, syncs inactive, DISP_EN/strobes 0. At a tick with ENABLE=1 -> RUN; that tick emits (0,0) with FRAME_START.
  RUN: counting. ENABLE=0 -> DRAIN.
  DRAIN: counting continues. ENABLE=1 -> RUN. At the tick with hc=H_TOTAL-1, vc=V_TOTAL-1 -> IDLE; counters cleared.
- Only whole frames are emitted. Reset mid-frame aborts immediately to reset values.

Optional Feature:
VGA_TEST_PATTERN_EN: adds outputs R, G, B (8 bits each), registered alongside DISP_EN. Eight vertical colour bars, each H_ACTIVE/8 wide (white, yellow, cyan, green, magenta, red, blue, black; 8'hFF/8'h00 components). Outputs are 0 when DISP_EN=0. Without the macro: no RGB ports and no bar logic.

Decomposition:
- Package vga_pkg: timing struct typedef (active/fp/sync/bp), 640x480@60 default constants, FSM state enum {IDLE, RUN, DRAIN}, colour-bar constant table.
- Sub-module vga_axis_counter (one counter + active/sync window decode), instantiated once horizontally and once vertically. Vertical instance advances on horizontal wrap.

Test Plan:
- Small timing (H 8/2/3/3, V 4/1/2/1, CLK_DIV 2), ENABLE=1 from reset -> FRAME_START one cycle every 16*8*2=256 clk50; H_SYNC low exactly 3 ticks starting hc=10; V_SYNC low exactly 2 lines starting vc=5.
- Same timing -> DISP_EN high 8 ticks per line on lines 0..3 only; XPOS 0..7; N_BLANK==DISP_EN; XPOS/YPOS 0 in blanking.
- Drop ENABLE at vc=2 -> full frame completes through hc=15,vc=7, then IDLE with syncs high; reassert in DRAIN at vc=6 -> no gap, next FRAME_START on schedule.
- HSYNC_POL=1, VSYNC_POL=1 -> idle level 0, pulse level 1, same windows.
- Assert N_RESET low mid-line at hc=5 -> all outputs reset values in same cycle, asynchronously; after release, first FRAME_START at the first tick with ENABLE=1.
- Defaults with VGA_TEST_PATTERN_EN -> pixel (80,0) is yellow FF/FF/00, (639,479) is black, RGB 0 at hc=640; 800x525 ticks per frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA raster generator:
// axis timing struct, 640x480@60 defaults, FSM states and colour-bar table.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam vga_timing_t VGA_640X480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2, bp: 16'd33};
    localparam int          VGA_DEF_CLK_DIV = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } vga_state_t;

    // Left-to-right bar colours, packed as {R, G, B}
    localparam logic [0:7][23:0] COLOUR_BARS = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with active-region and sync-window decode.
// Latency: counter updates on the edge where adv is high; decodes are combinational.
// Backpressure: none; advances only when adv is asserted.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC_W = 96,
    parameter int BP     = 48,
    parameter int W      = $clog2(ACTIVE + FP + SYNC_W + BP)
) (
    input  logic         clk50,
    input  logic         rst_n,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic         at_last,
    output logic         in_active,
    output logic         in_sync
);
    localparam int           TOTAL      = ACTIVE + FP + SYNC_W + BP;
    localparam int           SYNC_START = ACTIVE + FP;
    localparam int           SYNC_END   = ACTIVE + FP + SYNC_W;
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

    assign at_last   = (cnt == LAST);
    assign in_active = (int'(cnt) < ACTIVE);
    assign in_sync   = (int'(cnt) >= SYNC_START) && (int'(cnt) < SYNC_END);

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: syncs, blanking, coordinates, strobes; VGA_TEST_PATTERN_EN adds R/G/B bars.
// Latency: outputs registered on the clk50 edge after each pixel tick, held for CLK_DIV cycles.
// Backpressure: none; free-running once enabled, ENABLE low stops only after the current frame.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = int'(VGA_640X480_H.active),
    parameter int H_FP      = int'(VGA_640X480_H.fp),
    parameter int H_SYNC_W  = int'(VGA_640X480_H.sync),
    parameter int H_BP      = int'(VGA_640X480_H.bp),
    parameter int V_ACTIVE  = int'(VGA_640X480_V.active),
    parameter int V_FP      = int'(VGA_640X480_V.fp),
    parameter int V_SYNC_W  = int'(VGA_640X480_V.sync),
    parameter int V_BP      = int'(VGA_640X480_V.bp),
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = VGA_DEF_CLK_DIV,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC_W + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC_W + V_BP,
    localparam int XW       = $clog2(H_TOTAL),
    localparam int YW       = $clog2(V_TOTAL)
) (
    input  logic          clk50,
    input  logic          N_RESET,
    input  logic          ENABLE,
    output logic          VGA_CLOCK,
    output logic          PIX_TICK,
    output logic          H_SYNC,
    output logic          V_SYNC,
    output logic          N_SYNC,
    output logic          N_BLANK,
    output logic          DISP_EN,
    output logic [XW-1:0] XPOS,
    output logic [YW-1:0] YPOS,
`ifdef VGA_TEST_PATTERN_EN
    output logic [7:0]    R,
    output logic [7:0]    G,
    output logic [7:0]    B,
`endif
    output logic          LINE_START,
    output logic          FRAME_START
);
    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be even and >= 2");
    end

    logic [DW-1:0] divcnt;
    logic [DW-1:0] divcnt_nxt;
    logic          tick;

    assign tick       = (divcnt == DIV_LAST);
    assign divcnt_nxt = tick ? '0 : divcnt + 1'b1;

    // VGA_CLOCK follows the next divider phase so its rising edge lands mid-pixel
    always_ff @(posedge clk50 or negedge N_RESET) begin
        if (!N_RESET) begin
            divcnt    <= '0;
            PIX_TICK  <= 1'b0;
            VGA_CLOCK <= 1'b0;
        end else begin
            divcnt    <= divcnt_nxt;
            PIX_TICK  <= tick;
            VGA_CLOCK <= (divcnt_nxt >= DIV_HALF);
        end
    end

    logic [XW-1:0] hc;
    logic [YW-1:0] vc;
    logic          h_last, h_act, h_sync_win;
    logic          v_last, v_act, v_sync_win;
    logic          emit;
    logic          disp;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC_W (H_SYNC_W),
        .BP     (H_BP),
        .W      (XW)
    ) u_h_axis (
        .clk50     (clk50),
        .rst_n     (N_RESET),
        .adv       (emit),
        .cnt       (hc),
        .at_last   (h_last),
        .in_active (h_act),
        .in_sync   (h_sync_win)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC_W (V_SYNC_W),
        .BP     (V_BP),
        .W      (YW)
    ) u_v_axis (
        .clk50     (clk50),
        .rst_n     (N_RESET),
        .adv       (emit && h_last),
        .cnt       (vc),
        .at_last   (v_last),
        .in_active (v_act),
        .in_sync   (v_sync_win)
    );

    vga_state_t state, state_nxt;

    always_ff @(posedge clk50 or negedge N_RESET) begin
        if (!N_RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // emit marks a tick that outputs a raster position; counters advance with it
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        case (state)
            IDLE: begin
                if (tick && ENABLE) begin
                    state_nxt = RUN;
                    emit      = 1'b1;
                end
            end
            RUN: begin
                emit = tick;
                if (!ENABLE) state_nxt = DRAIN;
            end
            DRAIN: begin
                emit = tick;
                if (ENABLE) state_nxt = RUN;
                else if (tick && h_last && v_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign disp   = emit && h_act && v_act;
    assign N_SYNC = 1'b0;
    assign N_BLANK = DISP_EN;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    int         bar_q;
    logic [2:0] bar_idx;

    assign bar_q   = int'(hc) / BAR_W;
    assign bar_idx = (bar_q > 7) ? 3'd7 : bar_q[2:0];

    always_ff @(posedge clk50 or negedge N_RESET) begin
        if (!N_RESET) begin
            {R, G, B} <= 24'h0;
        end else if (tick) begin
            {R, G, B} <= disp ? COLOUR_BARS[bar_idx] : 24'h0;
        end
    end
`endif

    always_ff @(posedge clk50 or negedge N_RESET) begin
        if (!N_RESET) begin
            H_SYNC      <= ~HSYNC_POL;
            V_SYNC      <= ~VSYNC_POL;
            DISP_EN     <= 1'b0;
            XPOS        <= '0;
            YPOS        <= '0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            if (tick) begin
                H_SYNC      <= (emit && h_sync_win) ? HSYNC_POL : ~HSYNC_POL;
                V_SYNC      <= (emit && v_sync_win) ? VSYNC_POL : ~VSYNC_POL;
                DISP_EN     <= disp;
                XPOS        <= disp ? hc : '0;
                YPOS        <= disp ? vc : '0;
                LINE_START  <= emit && (hc == '0);
                FRAME_START <= emit && (hc == '0) && (vc == '0);
            end
        end
    end

endmodule
